// File: rtl/bcd2bin_seq.sv
// Three-digit BCD to binary converter: multiply-by-10 and accumulate over three
// cycles behind a start/done handshake, with saturation and bad-digit flagging.
module bcd2bin_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       hundreds,
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    output logic [WIDTH-1:0] binary,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             invalid
);

    typedef enum logic [1:0] {
        IDLE,
        ACC_H,
        ACC_T,
        ACC_O
    } state_t;

    localparam logic [9:0] MAX_VALUE = 10'((2 ** WIDTH) - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] dig_h;
    logic [3:0] dig_t;
    logic [3:0] dig_o;
    logic       digit_error;
    logic [9:0] acc;
    logic [9:0] acc_x10;
    logic [9:0] final_value;
    logic       accept;

    // The ACC_O edge doubles as an IDLE edge so a held start gives one result per 3 cycles.
    assign accept      = start && ((state == IDLE) || (state == ACC_O));
    assign acc_x10     = (acc << 3) + (acc << 1);
    assign final_value = acc_x10 + {6'd0, dig_o};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? ACC_H : IDLE;
            ACC_H:   state_next = ACC_T;
            ACC_T:   state_next = ACC_O;
            ACC_O:   state_next = accept ? ACC_H : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dig_h       <= 4'd0;
            dig_t       <= 4'd0;
            dig_o       <= 4'd0;
            digit_error <= 1'b0;
            acc         <= 10'd0;
            binary      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ACC_H: acc <= {6'd0, dig_h};
                ACC_T: acc <= acc_x10 + {6'd0, dig_t};
                ACC_O: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (digit_error) begin
                        binary   <= '0;
                        invalid  <= 1'b1;
                        overflow <= 1'b0;
                    end else if (final_value > MAX_VALUE) begin
                        binary   <= MAX_VALUE[WIDTH-1:0];
                        overflow <= 1'b1;
                        invalid  <= 1'b0;
                    end else begin
                        binary   <= final_value[WIDTH-1:0];
                        overflow <= 1'b0;
                        invalid  <= 1'b0;
                    end
                end
                default: ;
            endcase
            // A capture in the completion cycle overrides the busy release above.
            if (accept) begin
                dig_h       <= hundreds;
                dig_t       <= tens;
                dig_o       <= ones;
                digit_error <= (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
                acc         <= 10'd0;
                busy        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: directed cases with literal expectations
// plus randomized traffic compared every cycle against an arithmetic model.
module tb_bcd2bin_seq;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] hundreds = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic [7:0] binary;
    logic       busy;
    logic       done;
    logic       overflow;
    logic       invalid;

    int checks = 0;
    int errors = 0;

    bcd2bin_seq #(.WIDTH(8)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .hundreds(hundreds),
        .tens(tens),
        .ones(ones),
        .binary(binary),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .invalid(invalid)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: cycles remaining until completion plus the decimal value of the request.
    int   rem = 0;
    int   cap_val = 0;
    bit   cap_err = 1'b0;
    bit   model_valid = 1'b0;
    int   exp_binary = 0;
    bit   exp_busy = 1'b0;
    bit   exp_done = 1'b0;
    bit   exp_overflow = 1'b0;
    bit   exp_invalid = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            rem          = 0;
            exp_binary   = 0;
            exp_busy     = 1'b0;
            exp_done     = 1'b0;
            exp_overflow = 1'b0;
            exp_invalid  = 1'b0;
            model_valid  = 1'b1;
        end else begin
            exp_done = 1'b0;
            if (rem == 1) begin
                exp_done = 1'b1;
                if (cap_err) begin
                    exp_binary = 0; exp_invalid = 1'b1; exp_overflow = 1'b0;
                end else if (cap_val > 255) begin
                    exp_binary = 255; exp_invalid = 1'b0; exp_overflow = 1'b1;
                end else begin
                    exp_binary = cap_val; exp_invalid = 1'b0; exp_overflow = 1'b0;
                end
            end
            if (rem > 0) rem--;
            if (rem == 0 && start) begin
                cap_val = int'(hundreds) * 100 + int'(tens) * 10 + int'(ones);
                cap_err = (hundreds > 9) || (tens > 9) || (ones > 9);
                rem     = 3;
            end
            exp_busy = (rem > 0);
        end
    end

    always @(negedge clock) begin
        if (model_valid) begin
            check_output("binary", int'(binary), exp_binary);
            check_output("busy", int'(busy), int'(exp_busy));
            check_output("done", int'(done), int'(exp_done));
            check_output("overflow", int'(overflow), int'(exp_overflow));
            check_output("invalid", int'(invalid), int'(exp_invalid));
        end
    end

    // Issues one request, waits (bounded) for done, then pins the result to literals.
    task automatic apply_stimulus(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                                  input int exp_bin, input bit exp_ovf, input bit exp_inv);
        bit seen;
        @(negedge clock);
        start = 1'b1; hundreds = h; tens = t; ones = o;
        @(negedge clock);
        start = 1'b0;
        hundreds = 4'($urandom_range(0, 15));
        tens = 4'($urandom_range(0, 15));
        ones = 4'($urandom_range(0, 15));
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check_output("done_seen", int'(seen), 1);
        check_output("lit_binary", int'(binary), exp_bin);
        check_output("lit_overflow", int'(overflow), int'(exp_ovf));
        check_output("lit_invalid", int'(invalid), int'(exp_inv));
    endtask

    initial begin
        int pulses;
        int dones;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_output("reset_binary", int'(binary), 0);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_done", int'(done), 0);

        apply_stimulus(4'd1, 4'd2, 4'd3, 8'h7B, 1'b0, 1'b0);
        @(negedge clock);
        check_output("done_drops", int'(done), 0);

        apply_stimulus(4'd0, 4'd0, 4'd0, 0, 1'b0, 1'b0);
        apply_stimulus(4'd2, 4'd5, 4'd5, 255, 1'b0, 1'b0);
        apply_stimulus(4'd2, 4'd5, 4'd6, 255, 1'b1, 1'b0);
        apply_stimulus(4'd9, 4'd9, 4'd9, 255, 1'b1, 1'b0);
        apply_stimulus(4'd1, 4'hA, 4'd3, 0, 1'b0, 1'b1);
        apply_stimulus(4'd0, 4'd4, 4'd2, 42, 1'b0, 1'b0);

        // Second start one cycle after acceptance must be ignored.
        @(negedge clock);
        start = 1'b1; hundreds = 4'd0; tens = 4'd6; ones = 4'd4;
        @(negedge clock);
        hundreds = 4'd9; tens = 4'd9; ones = 4'd9;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        check_output("ignored_done", int'(done), 1);
        check_output("ignored_binary", int'(binary), 64);
        @(negedge clock);
        check_output("ignored_idle", int'(busy), 0);

        // Start held for 9 edges yields three results.
        @(negedge clock);
        start = 1'b1; hundreds = 4'd1; tens = 4'd0; ones = 4'd0;
        pulses = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            if (i == 8) start = 1'b0;
            if (done) begin
                pulses++;
                check_output("held_binary", int'(binary), 100);
            end
        end
        check_output("held_pulses", pulses, 3);

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clock);
        start = 1'b1; hundreds = 4'd1; tens = 4'd2; ones = 4'd3;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_binary", int'(binary), 0);
        dones = 0;
        repeat (5) begin
            @(negedge clock);
            if (done) dones++;
        end
        check_output("abort_no_done", dones, 0);
        apply_stimulus(4'd0, 4'd0, 4'd7, 7, 1'b0, 1'b0);

        // Randomized traffic checked by the model each cycle.
        for (int i = 0; i < 800; i++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 99) < 2);
            start = ($urandom_range(0, 1) == 1);
            hundreds = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
            tens = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
            ones = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
        end
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        repeat (5) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
